multu_hilo: RTL and testbench

Sequential unsigned multiplier with its HI/LO register pair. It is the producer behind the `HiOut`/`LoOut` inputs of the writeback selector. On a MULTU function code it computes the 64-bit unsigned product of two 32-bit operands with a shift-add loop, one bit per cycle. It commits the result to HI/LO only when the product is complete. MFHI/MFLO read these registers through the writeback selector.

---
 rtl/cpu_funct_pkg.sv | 22 ++
 rtl/multu_hilo_if.sv | 23 ++
 rtl/multu_shift_add.sv | 58 +++++
 rtl/multu_hilo.sv | 82 ++++++++
 tb/tb_multu_hilo.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_funct_pkg.sv
// Function codes shared by the multiplier and the writeback selector, plus
// the multiplier control state type.
package cpu_funct_pkg;

    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/multu_hilo_if.sv
// Request/result bundle between the issuing stage and the HI/LO multiplier.
interface multu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [WIDTH-1:0] HiOut;
    logic [WIDTH-1:0] LoOut;
    logic             busy;
    logic             done;

    modport master (
        output start, Signal, dataA, dataB,
        input  HiOut, LoOut, busy, done
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output HiOut, LoOut, busy, done
    );
endinterface

// File: rtl/multu_shift_add.sv
// Shift-add product engine: one multiplier bit per cycle, exposes the
// product as it will stand after the current step.
module multu_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH:0] p_q, p_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    // Bit 2W of P is always zero between steps, so summing all W+1 upper bits
    // is the same as adding A to the upper W bits with the carry kept.
    always_comb begin
        sum = p_q[0] ? (p_q[2*WIDTH:WIDTH] + {1'b0, a_q}) : p_q[2*WIDTH:WIDTH];
        hi  = sum[WIDTH:1];
        lo  = {sum[0], p_q[WIDTH-1:1]};
    end

    always_comb begin
        p_d   = p_q;
        a_d   = a_q;
        cnt_d = cnt_q;
        if (load) begin
            p_d   = {{(WIDTH+1){1'b0}}, b_in};
            a_d   = a_in;
            cnt_d = '0;
        end else if (run) begin
            p_d   = {1'b0, sum, p_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            a_q   <= '0;
            cnt_q <= '0;
        end else begin
            p_q   <= p_d;
            a_q   <= a_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/multu_hilo.sv
// Sequential MULTU unit owning the HI/LO pair; HI/LO change only on commit.
// Define MULTU_HILO_MTHI_MTLO_EN to also accept MTHI/MTLO writes from dataA.
//
//   state   | meaning
//   ST_IDLE | HI/LO stable, accepting requests
//   ST_RUN  | shift-add iterations in progress, requests ignored
module multu_hilo
    import cpu_funct_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    multu_hilo_if.slave  bus
);
    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             start_mul;
    logic             last;
    logic [WIDTH-1:0] prod_hi, prod_lo;

    assign start_mul = bus.start && (bus.Signal == FN_MULTU) && (state_q == ST_IDLE);

    multu_shift_add #(.WIDTH(WIDTH)) u_engine (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_mul),
        .run   (state_q == ST_RUN),
        .a_in  (bus.dataA),
        .b_in  (bus.dataB),
        .last  (last),
        .hi    (prod_hi),
        .lo    (prod_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_mul) state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        if ((state_q == ST_RUN) && last) begin
            hi_d   = prod_hi;
            lo_d   = prod_lo;
            done_d = 1'b1;
        end
`ifdef MULTU_HILO_MTHI_MTLO_EN
        else if ((state_q == ST_IDLE) && bus.start) begin
            if (bus.Signal == FN_MTHI) hi_d = bus.dataA;
            if (bus.Signal == FN_MTLO) lo_d = bus.dataA;
        end
`endif
    end

    assign bus.HiOut = hi_q;
    assign bus.LoOut = lo_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = done_q;
endmodule

// File: tb/tb_multu_hilo.sv
// Scoreboarded bench for multu_hilo: products predicted with 64-bit arithmetic.
module tb_multu_hilo;
    import cpu_funct_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   last_e0;
    logic [31:0] com_hi;
    logic [31:0] com_lo;
    exp_t sb[$];

    multu_hilo_if #(.WIDTH(W)) bus ();

    multu_hilo #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_busy();
        return (cyc >= last_e0) && (cyc < last_e0 + W);
    endfunction

    function automatic logic [31:0] pick();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'h0;
        if (r == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    // Monitor: compares flags every cycle and commits expected products on done.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_done;
        exp_done = (sb.size() > 0) && (sb[0].due == cyc);
        check("busy", {63'd0, bus.busy}, {63'd0, model_busy()});
        check("done", {63'd0, bus.done}, {63'd0, exp_done});
        if (bus.done && sb.size() > 0) begin
            e = sb.pop_front();
            com_hi = e.hi;
            com_lo = e.lo;
        end
        check("HiOut", {32'd0, bus.HiOut}, {32'd0, com_hi});
        check("LoOut", {32'd0, bus.LoOut}, {32'd0, com_lo});
    end

    // Called at posedge+1; presents one request for the next edge.
    task automatic drive(input logic st, input logic [5:0] sig,
                         input logic [31:0] a, input logic [31:0] b);
        int          n;
        bit          free;
        logic [63:0] prod;
        bit          mthi, mtlo;
        bus.start  = st;
        bus.Signal = sig;
        bus.dataA  = a;
        bus.dataB  = b;
        n    = cyc + 1;
        free = (n >= last_e0 + W + 1);
        mthi = 1'b0;
        mtlo = 1'b0;
        if (st && free && sig == FN_MULTU) begin
            prod    = 64'(a) * 64'(b);
            last_e0 = n;
            sb.push_back('{hi: prod[63:32], lo: prod[31:0], due: n + W});
        end
`ifdef MULTU_HILO_MTHI_MTLO_EN
        mthi = st && free && (sig == FN_MTHI);
        mtlo = st && free && (sig == FN_MTLO);
`endif
        @(posedge clk);
        #1;
        if (mthi) com_hi = a;
        if (mtlo) com_lo = a;
        bus.start  = 1'b0;
        bus.Signal = 6'(pick());
        bus.dataA  = pick();
        bus.dataB  = pick();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
            bus.dataA = pick();
            bus.dataB = pick();
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() > 0 || model_busy()) && t < 200) begin
            idle(1);
            t++;
        end
        if (t >= 200) check("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_free();
        int t;
        t = 0;
        while ((cyc + 1 < last_e0 + W + 1) && t < 200) begin
            idle(1);
            t++;
        end
        if (t >= 200) check("wait_free_timeout", 64'd1, 64'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        com_hi  = '0;
        com_lo  = '0;
        last_e0 = -1000;
    endtask

    initial begin
        int op;
        checks = 0;
        errors = 0;
        model_reset();
        rst_n      = 1'b1;
        bus.start  = 1'b0;
        bus.Signal = FN_SLL;
        bus.dataA  = '0;
        bus.dataB  = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_hi",   {32'd0, bus.HiOut}, 64'd0);
        check("rst_lo",   {32'd0, bus.LoOut}, 64'd0);
        check("rst_busy", {63'd0, bus.busy},  64'd0);
        check("rst_done", {63'd0, bus.done},  64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Carry path, then 3 x 5 over a non-zero committed pair.
        drive(1'b1, FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        check("ff_hi", {32'd0, bus.HiOut}, 64'h0000_0000_FFFF_FFFE);
        check("ff_lo", {32'd0, bus.LoOut}, 64'h0000_0000_0000_0001);
`ifdef MULTU_HILO_MTHI_MTLO_EN
        drive(1'b1, FN_MTHI, 32'hAAAA_AAAA, 32'h0);
        drive(1'b1, FN_MTLO, 32'h5555_5555, 32'h0);
`endif
        drive(1'b1, FN_MULTU, 32'd3, 32'd5);
        wait_idle();
        check("p15_hi", {32'd0, bus.HiOut}, 64'd0);
        check("p15_lo", {32'd0, bus.LoOut}, 64'd15);

        // Ignored requests: mid-run start, wrong code, MULTU without start.
        drive(1'b1, FN_MULTU, 32'h0001_2345, 32'h0006_789A);
        idle(4);
        drive(1'b1, FN_MULTU, 32'd2, 32'd2);
        wait_idle();
        drive(1'b1, FN_ADD, pick(), pick());
        idle(2);
        drive(1'b0, FN_MULTU, pick(), pick());
        idle(2);

        // Back-to-back: second start lands in the done cycle.
        drive(1'b1, FN_MULTU, pick(), pick());
        wait_free();
        drive(1'b1, FN_MULTU, pick(), pick());
        wait_idle();

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                6:       drive(1'b1, FN_ADD,   pick(), pick());
                7:       drive(1'b0, FN_MULTU, pick(), pick());
                8:       drive(1'b1, FN_MTHI,  pick(), pick());
                9:       drive(1'b1, FN_MTLO,  pick(), pick());
                default: drive(1'b1, FN_MULTU, pick(), pick());
            endcase
            idle($urandom_range(0, 12));
        end
        wait_idle();

        // Asynchronous abort at cycle 10 of a run.
        drive(1'b1, FN_MULTU, pick(), pick());
        idle(9);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_hi",   {32'd0, bus.HiOut}, 64'd0);
        check("abort_lo",   {32'd0, bus.LoOut}, 64'd0);
        check("abort_busy", {63'd0, bus.busy},  64'd0);
        check("abort_done", {63'd0, bus.done},  64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b1, FN_MULTU, 32'd7, 32'd6);
        wait_idle();
        check("after_abort_lo", {32'd0, bus.LoOut}, 64'd42);

        // MTHI when idle, MTLO while busy (effects depend on build).
        drive(1'b1, FN_MTHI, 32'h1234_5678, 32'h0);
        check("mthi_hi", {32'd0, bus.HiOut}, {32'd0, com_hi});
        drive(1'b1, FN_MULTU, 32'd9, 32'd11);
        idle(3);
        drive(1'b1, FN_MTLO, 32'hDEAD_BEEF, 32'h0);
        wait_idle();
        check("mtlo_busy_lo", {32'd0, bus.LoOut}, 64'd99);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
